mantissa_addsub_pipe: RTL and testbench
=======================================

MANTISSA_ADDSUB_PIPE -- requirements
Module: mantissa_addsub_pipe

Interface
REQ-001 Parameter MANT_W, default 24: mantissa width including hidden bit; legal range 8..64.
REQ-002 Parameter LANES, default 1: number of independent add/sub lanes sharing one handshake; legal range 1..8.
REQ-003 Parameter STAGES, default 1: pipeline depth; legal values 1 or 2.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-high.
REQ-006 in_valid  in  1  input beat present.
REQ-007 in_ready  out  1  block accepts beat this cycle.
REQ-008 sign_a  in  LANES  per-lane sign of larger-exponent operand.
REQ-009 sign_b  in  LANES  per-lane sign of smaller-exponent operand.
REQ-010 mant_big  in  LANES*MANT_W  per-lane aligned mantissa of sign_a operand; lane i at [i*MANT_W +: MANT_W].
REQ-011 mant_small  in  LANES*MANT_W  per-lane aligned mantissa of sign_b operand; same packing.
REQ-012 out_valid  out  1  result beat present.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 res_sign  out  LANES  per-lane result sign.
REQ-015 res_mag  out  LANES*(MANT_W+1)  per-lane unsigned magnitude, carry bit at MSB.
REQ-016 res_zero  out  LANES  per-lane flag, magnitude exactly zero.
REQ-017 res_lzc  out  LANES*LZC_W  per-lane leading-zero count of res_mag, LZC_W = clog2(MANT_W+2).

Function
REQ-018 Per lane, diff = sign_a XOR sign_b; all arithmetic on MANT_W+1-bit zero-extended operands.
REQ-019 diff=0: mag = big+small, sign = sign_a.
REQ-020 diff=1 and big >= small: mag = big-small, sign = sign_a.
REQ-021 diff=1 and big < small: mag = small-big, sign = sign_b.
REQ-022 mag=0 (exact cancellation or both zero): sign forced to 0, res_zero=1, res_lzc=MANT_W+1.
REQ-023 res_lzc counts zeros from res_mag MSB down to the first 1; 0 when carry bit is set.
REQ-024 Beat transfers in when in_valid & in_ready; out when out_valid & out_ready.
REQ-025 Latency exactly STAGES cycles from input transfer to out_valid with no backpressure.
REQ-026 STAGES=1: single register stage computes sign/mag/zero/lzc; in_ready = !out_valid | out_ready.
REQ-027 STAGES=2: stage 1 registers sign, mag; stage 2 registers zero, lzc plus forwarded sign, mag; each stage loads when empty or when its content moves on in the same cycle.
REQ-028 Throughput one beat per cycle under continuous out_ready=1.
REQ-029 While out_valid=1 and out_ready=0, all outputs hold stable; no beat dropped or duplicated.
REQ-030 Full pipeline with out_ready=0: in_ready=0 combinationally; simultaneous drain and fill in the same cycle allowed.
REQ-031 Data registers load only on stage advance; valid bits update every cycle.
REQ-032 All lanes share one valid; lanes never diverge in timing.

Reset
REQ-033 rst=1 clears all stage valid bits immediately; out_valid=0, res_sign=0, res_mag=0, res_zero=0, res_lzc=0.
REQ-034 in_ready=1 during and after reset.
REQ-035 Reset mid-operation discards all in-flight beats; first beat after release obeys REQ-025.

Structure
REQ-036 Shared package fp_pkg holds LZC_W function, stage-valid typedef, default MANT_W constant.
REQ-037 One sub-module lzc_unit (width-parametrised leading-zero counter), instantiated per lane.

Verification (MANT_W=24, LANES=1 unless stated)
REQ-038 sign_a=0, sign_b=0, big=0x800000, small=0x800000 -> mag=0x1000000, sign=0, zero=0, lzc=0.
REQ-039 sign_a=0, sign_b=1, big=0xC00000, small=0x800000 -> mag=0x0400000, sign=0, lzc=2.
REQ-040 sign_a=0, sign_b=1, big=0x800000, small=0xA00000 -> mag=0x0200000, sign=1, lzc=3.
REQ-041 sign_a=1, sign_b=0, big=small=0x9ABCDE -> mag=0, sign=0, zero=1, lzc=25.
REQ-042 STAGES=2, three back-to-back beats, out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, output held stable, all 3 results emitted in order.
REQ-043 LANES=4 mixed cases, rst pulsed with 2 beats in flight -> out_valid=0 same cycle, no stale beat after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the mantissa add/sub datapath: the leading-zero count
// width, the per-stage valid vector and the default mantissa width.
package fp_pkg;

    localparam int DEF_MANT_W = 24;

    // One valid bit per pipeline stage (the pipeline is at most two deep).
    typedef logic [1:0] stage_vld_t;

    // The count must reach MANT_W+1, so it needs clog2(MANT_W+2) bits.
    function automatic int lzc_w(input int mant_w);
        return $clog2(mant_w + 2);
    endfunction

endpackage

// File: rtl/mantissa_addsub_pipe_if.sv
// Input beat / result beat bundle for mantissa_addsub_pipe. The slave modport
// is the datapath side and the master modport is the producer/consumer side.
interface mantissa_addsub_pipe_if #(
    parameter int MANT_W = fp_pkg::DEF_MANT_W,
    parameter int LANES  = 1
);
    localparam int LZC_W = fp_pkg::lzc_w(MANT_W);

    logic                        in_valid;
    logic                        in_ready;
    logic [LANES-1:0]            sign_a;
    logic [LANES-1:0]            sign_b;
    logic [LANES*MANT_W-1:0]     mant_big;
    logic [LANES*MANT_W-1:0]     mant_small;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES-1:0]            res_sign;
    logic [LANES*(MANT_W+1)-1:0] res_mag;
    logic [LANES-1:0]            res_zero;
    logic [LANES*LZC_W-1:0]      res_lzc;

    modport master (
        output in_valid, sign_a, sign_b, mant_big, mant_small, out_ready,
        input  in_ready, out_valid, res_sign, res_mag, res_zero, res_lzc
    );

    modport slave (
        input  in_valid, sign_a, sign_b, mant_big, mant_small, out_ready,
        output in_ready, out_valid, res_sign, res_mag, res_zero, res_lzc
    );

endinterface

// File: rtl/lzc_unit.sv
// Combinational leading-zero counter. An all-zero input reports W.
module lzc_unit #(
    parameter int W     = 25,
    parameter int OUT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     i_val,
    output logic [OUT_W-1:0] o_cnt
);

    // Scanning upwards lets the highest set bit take the final assignment.
    always_comb begin
        o_cnt = OUT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (i_val[i]) begin
                o_cnt = OUT_W'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/mantissa_addsub_pipe.sv
// Multi-lane signed-magnitude mantissa add/sub with zero flag and leading-zero
// count; STAGES (1 or 2) cycles latency, valid/ready with full drain-and-fill.
module mantissa_addsub_pipe
    import fp_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W,
    parameter int LANES  = 1,
    parameter int STAGES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mantissa_addsub_pipe_if.slave bus
);

    localparam int MW = MANT_W + 1;
    localparam int LW = lzc_w(MANT_W);

    stage_vld_t            r_vld;
    logic                  w_in_rdy;
    logic [LANES-1:0]      w_sign;
    logic [LANES*MW-1:0]   w_mag;
    logic [LANES-1:0]      r_o_sign;
    logic [LANES*MW-1:0]   r_o_mag;
    logic [LANES-1:0]      r_o_zero;
    logic [LANES*LW-1:0]   r_o_lzc;

    // Returns {sign, magnitude}; a zero magnitude always carries a positive sign.
    function automatic logic [MW:0] lane_addsub(
        input logic              sa,
        input logic              sb,
        input logic [MANT_W-1:0] mb,
        input logic [MANT_W-1:0] ms
    );
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [MW-1:0] m;
        logic          s;
        a = {1'b0, mb};
        b = {1'b0, ms};
        if (sa == sb) begin
            m = a + b;
            s = sa;
        end else if (a >= b) begin
            m = a - b;
            s = sa;
        end else begin
            m = b - a;
            s = sb;
        end
        if (m == '0) begin
            s = 1'b0;
        end
        return {s, m};
    endfunction

    always_comb begin
        w_sign = '0;
        w_mag  = '0;
        for (int l = 0; l < LANES; l++) begin
            {w_sign[l], w_mag[l*MW +: MW]} = lane_addsub(bus.sign_a[l], bus.sign_b[l],
                                                         bus.mant_big[l*MANT_W +: MANT_W],
                                                         bus.mant_small[l*MANT_W +: MANT_W]);
        end
    end

    generate
        if (STAGES == 1) begin : g_one
            logic [LANES-1:0]    w_zero;
            logic [LANES*LW-1:0] w_lzc;

            for (genvar l = 0; l < LANES; l++) begin : g_lane
                lzc_unit #(.W(MW), .OUT_W(LW)) u_lzc (
                    .i_val (w_mag[l*MW +: MW]),
                    .o_cnt (w_lzc[l*LW +: LW])
                );
                assign w_zero[l] = ~|w_mag[l*MW +: MW];
            end

            assign w_in_rdy = !r_vld[0] || bus.out_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld    <= '0;
                    r_o_sign <= '0;
                    r_o_mag  <= '0;
                    r_o_zero <= '0;
                    r_o_lzc  <= '0;
                end else begin
                    r_vld <= {1'b0, w_in_rdy ? bus.in_valid : r_vld[0]};
                    if (bus.in_valid && w_in_rdy) begin
                        r_o_sign <= w_sign;
                        r_o_mag  <= w_mag;
                        r_o_zero <= w_zero;
                        r_o_lzc  <= w_lzc;
                    end
                end
            end
        end else begin : g_two
            logic [LANES-1:0]    r_s1_sign;
            logic [LANES*MW-1:0] r_s1_mag;
            logic [LANES-1:0]    w_zero;
            logic [LANES*LW-1:0] w_lzc;
            logic                w_s2_rdy;

            // The leading-zero count runs in the second stage, off registered magnitudes.
            for (genvar l = 0; l < LANES; l++) begin : g_lane
                lzc_unit #(.W(MW), .OUT_W(LW)) u_lzc (
                    .i_val (r_s1_mag[l*MW +: MW]),
                    .o_cnt (w_lzc[l*LW +: LW])
                );
                assign w_zero[l] = ~|r_s1_mag[l*MW +: MW];
            end

            assign w_s2_rdy = !r_vld[1] || bus.out_ready;
            assign w_in_rdy = !r_vld[0] || w_s2_rdy;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld     <= '0;
                    r_s1_sign <= '0;
                    r_s1_mag  <= '0;
                    r_o_sign  <= '0;
                    r_o_mag   <= '0;
                    r_o_zero  <= '0;
                    r_o_lzc   <= '0;
                end else begin
                    r_vld[0] <= w_in_rdy ? bus.in_valid : r_vld[0];
                    r_vld[1] <= w_s2_rdy ? r_vld[0] : r_vld[1];
                    if (bus.in_valid && w_in_rdy) begin
                        r_s1_sign <= w_sign;
                        r_s1_mag  <= w_mag;
                    end
                    if (r_vld[0] && w_s2_rdy) begin
                        r_o_sign <= r_s1_sign;
                        r_o_mag  <= r_s1_mag;
                        r_o_zero <= w_zero;
                        r_o_lzc  <= w_lzc;
                    end
                end
            end
        end
    endgenerate

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = (STAGES == 1) ? r_vld[0] : r_vld[1];
    assign bus.res_sign  = r_o_sign;
    assign bus.res_mag   = r_o_mag;
    assign bus.res_zero  = r_o_zero;
    assign bus.res_lzc   = r_o_lzc;

endmodule

// File: tb/tb_mantissa_addsub_pipe.sv
// Scoreboard bench: a single-lane one-stage instance and a four-lane two-stage
// instance driven from one table of hand-computed vectors.
module tb_mantissa_addsub_pipe;

    localparam int MW = 24;
    localparam int LB = 4;
    localparam int NV = 10;

    typedef struct packed {
        logic        sa;
        logic        sb;
        logic [23:0] big;
        logic [23:0] sml;
        logic        s;
        logic [24:0] mag;
        logic        z;
        logic [4:0]  lzc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mantissa_addsub_pipe_if #(.MANT_W(MW), .LANES(1))  ia ();
    mantissa_addsub_pipe_if #(.MANT_W(MW), .LANES(LB)) ib ();

    mantissa_addsub_pipe #(.MANT_W(MW), .LANES(1), .STAGES(1)) dut_a (
        .clk (clk), .rst (rst), .bus (ia)
    );
    mantissa_addsub_pipe #(.MANT_W(MW), .LANES(LB), .STAGES(2)) dut_b (
        .clk (clk), .rst (rst), .bus (ib)
    );

    vec_t           tv [NV];
    logic [31:0]    q_a [$];
    logic [127:0]   q_b [$];
    int             n_cmp = 0;
    int             n_bad = 0;
    logic           rdy_a = 1'b1, rdy_b = 1'b1;
    logic           bp_a = 1'b0, bp_b = 1'b0;
    logic           rnd_a = 1'b1, rnd_b = 1'b1;
    logic [31:0]    e_a;
    logic [127:0]   e_b;
    logic [127:0]   snap;

    assign ia.out_ready = bp_a ? rnd_a : rdy_a;
    assign ib.out_ready = bp_b ? rnd_b : rdy_b;

    always begin
        @(posedge clk);
        #1;
        rnd_a = 1'($urandom_range(0, 1));
        rnd_b = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] act_a();
        return {ia.res_sign, ia.res_mag, ia.res_zero, ia.res_lzc};
    endfunction

    function automatic logic [127:0] act_b();
        return {ib.res_sign, ib.res_mag, ib.res_zero, ib.res_lzc};
    endfunction

    function automatic logic [31:0] exp_a(input int v);
        return {tv[v].s, tv[v].mag, tv[v].z, tv[v].lzc};
    endfunction

    function automatic logic [127:0] exp_b(input int k);
        logic [3:0]  s;
        logic [3:0]  z;
        logic [99:0] m;
        logic [19:0] c;
        vec_t        t;
        for (int l = 0; l < LB; l++) begin
            t            = tv[(k + l) % NV];
            s[l]         = t.s;
            z[l]         = t.z;
            m[l*25 +: 25] = t.mag;
            c[l*5 +: 5]   = t.lzc;
        end
        return {s, m, z, c};
    endfunction

    task automatic drive_a(input int v);
        ia.sign_a     = tv[v].sa;
        ia.sign_b     = tv[v].sb;
        ia.mant_big   = tv[v].big;
        ia.mant_small = tv[v].sml;
    endtask

    task automatic drive_b(input int k);
        for (int l = 0; l < LB; l++) begin
            ib.sign_a[l]               = tv[(k + l) % NV].sa;
            ib.sign_b[l]               = tv[(k + l) % NV].sb;
            ib.mant_big[l*MW +: MW]    = tv[(k + l) % NV].big;
            ib.mant_small[l*MW +: MW]  = tv[(k + l) % NV].sml;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_a(input int v);
        logic ok;
        int   guard;
        ok    = 1'b0;
        guard = 0;
        drive_a(v);
        ia.in_valid = 1'b1;
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = ia.in_ready;
            if (ok) q_a.push_back(exp_a(v));
            @(posedge clk);
            #1;
            guard++;
        end
        check("accept_a", ok, 1'b1);
        ia.in_valid = 1'b0;
    endtask

    task automatic send_b(input int k);
        logic ok;
        int   guard;
        ok    = 1'b0;
        guard = 0;
        drive_b(k);
        ib.in_valid = 1'b1;
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = ib.in_ready;
            if (ok) q_b.push_back(exp_b(k));
            @(posedge clk);
            #1;
            guard++;
        end
        check("accept_b", ok, 1'b1);
        ib.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && ia.out_valid && ia.out_ready) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_unexpected_beat: got %h, expected no beat", act_a());
            end else begin
                e_a = q_a.pop_front();
                check("a_result", act_a(), e_a);
            end
        end
        if (!rst && ib.out_valid && ib.out_ready) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_unexpected_beat: got %h, expected no beat", act_b());
            end else begin
                e_b = q_b.pop_front();
                check("b_result", act_b(), e_b);
            end
        end
    end

    initial begin
        //          sa    sb    big        small      s     mag          z     lzc
        tv[0] = '{1'b0, 1'b0, 24'h800000, 24'h800000, 1'b0, 25'h1000000, 1'b0, 5'd0};
        tv[1] = '{1'b0, 1'b1, 24'hC00000, 24'h800000, 1'b0, 25'h0400000, 1'b0, 5'd2};
        tv[2] = '{1'b0, 1'b1, 24'h800000, 24'hA00000, 1'b1, 25'h0200000, 1'b0, 5'd3};
        tv[3] = '{1'b1, 1'b0, 24'h9ABCDE, 24'h9ABCDE, 1'b0, 25'h0000000, 1'b1, 5'd25};
        tv[4] = '{1'b1, 1'b1, 24'h000001, 24'h000000, 1'b1, 25'h0000001, 1'b0, 5'd24};
        tv[5] = '{1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0, 25'h0000000, 1'b1, 5'd25};
        tv[6] = '{1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 25'h1FFFFFE, 1'b0, 5'd0};
        tv[7] = '{1'b1, 1'b0, 24'h400000, 24'h7FFFFF, 1'b0, 25'h03FFFFF, 1'b0, 5'd3};
        tv[8] = '{1'b0, 1'b1, 24'hFFFFFF, 24'h000001, 1'b0, 25'h0FFFFFE, 1'b0, 5'd1};
        tv[9] = '{1'b1, 1'b0, 24'h123456, 24'h000000, 1'b1, 25'h0123456, 1'b0, 5'd4};

        ia.in_valid = 1'b0; ia.sign_a = '0; ia.sign_b = '0; ia.mant_big = '0; ia.mant_small = '0;
        ib.in_valid = 1'b0; ib.sign_a = '0; ib.sign_b = '0; ib.mant_big = '0; ib.mant_small = '0;

        #3;
        check("rst_a_out_valid", ia.out_valid, 1'b0);
        check("rst_a_in_ready", ia.in_ready, 1'b1);
        check("rst_a_outputs", act_a(), '0);
        check("rst_b_out_valid", ib.out_valid, 1'b0);
        check("rst_b_in_ready", ib.in_ready, 1'b1);
        check("rst_b_outputs", act_b(), '0);
        #20 rst = 1'b0;

        // One-cycle latency on the single-stage instance.
        @(posedge clk); #1;
        drive_a(0);
        ia.in_valid = 1'b1;
        @(negedge clk);
        check("lat_a_in_ready", ia.in_ready, 1'b1);
        q_a.push_back(exp_a(0));
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        check("lat_a_out_valid", ia.out_valid, 1'b1);

        // Two-cycle latency on the two-stage instance.
        @(posedge clk); #1;
        drive_b(0);
        ib.in_valid = 1'b1;
        @(negedge clk);
        check("lat_b_in_ready", ib.in_ready, 1'b1);
        q_b.push_back(exp_b(0));
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
        check("lat_b_cycle1", ib.out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_b_cycle2", ib.out_valid, 1'b1);

        // Back-to-back streams with the sink always ready.
        for (int v = 0; v < NV; v++) send_a(v);
        for (int k = 0; k < NV; k++) send_b(k);
        wait_drain();

        // Stall a full two-stage pipeline: the third beat waits, outputs hold.
        rdy_b = 1'b0;
        send_b(1);
        send_b(2);
        drive_b(3);
        ib.in_valid = 1'b1;
        @(negedge clk);
        check("full_in_ready", ib.in_ready, 1'b0);
        check("full_out_valid", ib.out_valid, 1'b1);
        snap = act_b();
        check("full_head_beat", snap, exp_b(1));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("hold_out_valid", ib.out_valid, 1'b1);
            check("hold_data", act_b(), snap);
            check("hold_in_ready", ib.in_ready, 1'b0);
        end
        @(posedge clk); #1;
        rdy_b = 1'b1;
        send_b(3);
        wait_drain();

        // Random backpressure on both instances.
        bp_a = 1'b1;
        bp_b = 1'b1;
        for (int v = 0; v < NV; v++) send_a((v * 3) % NV);
        for (int k = 0; k < NV; k++) send_b((k * 7) % NV);
        bp_a = 1'b0;
        bp_b = 1'b0;
        wait_drain();

        // Reset with two beats in flight in the two-stage instance.
        rdy_b = 1'b0;
        send_b(4);
        send_b(5);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", ib.out_valid, 1'b0);
        check("midrst_in_ready", ib.in_ready, 1'b1);
        check("midrst_outputs", act_b(), '0);
        q_a.delete();
        q_b.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        rdy_b = 1'b1;
        @(posedge clk); #1;
        check("post_rst_empty", ib.out_valid, 1'b0);
        drive_b(6);
        ib.in_valid = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", ib.in_ready, 1'b1);
        q_b.push_back(exp_b(6));
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
        check("post_rst_lat1", ib.out_valid, 1'b0);
        @(posedge clk); #1;
        check("post_rst_lat2", ib.out_valid, 1'b1);
        for (int k = 7; k < 10; k++) send_b(k);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
